// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-unit types: FSM state encoding and the pass-through NOP word.
// Pure declarations; no logic, no latency, no flow control.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_00FF;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO: DEPTH x DW, synchronous clear, combinational head, push/pop same cycle.
// Zero-latency read of head; caller must never push when full or pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: one outstanding memory read at PC, prefetch FIFO, registered instruction output.
// MemValid at N reaches DataACKOut at N+2; Stall holds the FIFO and fetching stops when it fills.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Enable,
  output logic [AW-1:0] MemAddr,
  output logic          MemRd,
  input  logic [31:0]   MemData,
  input  logic          MemValid,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic [AW-1:0] BranchAddr,
  output logic [31:0]   InstructionBus,
  output logic          DataACKOut,
  output logic [AW-1:0] Pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [AW-1:0] pc;
  logic [31:0]   head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          clear;

  // A redirect kills both the incoming word and any pop scheduled for this cycle.
  always_comb begin
    clear = BranchEn && (state != ST_IDLE);
    push  = (state == ST_WAIT) && MemValid && !BranchEn;
    pop   = !BranchEn && !Stall && !fifo_empty;
  end

  fetch_fifo #(.DEPTH(DEPTH), .DW(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .wdata (MemData),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      MemRd   <= 1'b0;
      MemAddr <= RESET_PC;
    end else begin
      MemRd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (BranchEn) pc <= BranchAddr;
          if (Enable)   state <= ST_REQ;
        end
        ST_REQ: begin
          if (BranchEn) begin
            pc <= BranchAddr;
          end else if (!Enable) begin
            state <= ST_IDLE;
          end else if (fifo_count < CW'(DEPTH)) begin
            MemRd   <= 1'b1;
            MemAddr <= pc;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (MemValid) begin
            if (BranchEn) begin
              pc    <= BranchAddr;
              state <= ST_REQ;
            end else begin
              pc    <= pc + AW'(1);
              state <= Enable ? ST_REQ : ST_IDLE;
            end
          end else if (BranchEn) begin
            pc    <= BranchAddr;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The stale response still has to drain before a new read can go out.
          if (BranchEn) pc <= BranchAddr;
          if (MemValid) state <= Enable ? ST_REQ : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      InstructionBus <= NOP_INSTR;
      DataACKOut     <= 1'b0;
    end else if (pop) begin
      InstructionBus <= head;
      DataACKOut     <= 1'b1;
    end else begin
      InstructionBus <= NOP_INSTR;
      DataACKOut     <= 1'b0;
    end
  end

  assign Pc = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a memory model answers reads with addr+0x100 and a
// scoreboard matches every ACKed word and every checked MemAddr against queued expectations.
module tb_instruction_fetch;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          Enable;
  logic [AW-1:0] MemAddr;
  logic          MemRd;
  logic [31:0]   MemData;
  logic          MemValid;
  logic          Stall;
  logic          BranchEn;
  logic [AW-1:0] BranchAddr;
  logic [31:0]   InstructionBus;
  logic          DataACKOut;
  logic [AW-1:0] Pc;

  int n_vec     = 0;
  int n_err     = 0;
  int mrd_count = 0;
  int ack_count = 0;
  int lat       = 1;

  logic [31:0]   exp_q  [$];
  logic [AW-1:0] addr_q [$];

  logic          mem_pend = 1'b0;
  int            mem_cnt  = 0;
  logic [AW-1:0] mem_a    = '0;

  always #5 clk = ~clk;

  instruction_fetch #(.AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .Enable         (Enable),
    .MemAddr        (MemAddr),
    .MemRd          (MemRd),
    .MemData        (MemData),
    .MemValid       (MemValid),
    .Stall          (Stall),
    .BranchEn       (BranchEn),
    .BranchAddr     (BranchAddr),
    .InstructionBus (InstructionBus),
    .DataACKOut     (DataACKOut),
    .Pc             (Pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset(input int l);
    rst = 1'b1; Enable = 1'b0; Stall = 1'b0; BranchEn = 1'b0; BranchAddr = '0;
    lat = l;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_mrd(input int target);
    int k = 0;
    while (mrd_count < target && k < 300) begin
      tick();
      k++;
    end
    chk("mrd_wait", 32'(mrd_count >= target), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      tick();
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
  endtask

  task automatic expect_addrs(input logic [AW-1:0] first, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(first + AW'(i));
  endtask

  initial begin
    int base;
    int base_a;
    int k;
    rst = 1'b1; Enable = 1'b0; Stall = 1'b0; BranchEn = 1'b0; BranchAddr = '0;
    MemValid = 1'b0; MemData = '0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (DataACKOut) begin
            ack_count++;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_ack: got %h, no ACK expected", InstructionBus);
            end else begin
              chk("ack_data", InstructionBus, exp_q.pop_front());
            end
          end
          if (MemRd) begin
            mrd_count++;
            if (addr_q.size() != 0) chk("mem_addr", 32'(MemAddr), 32'(addr_q.pop_front()));
          end
        end
      end
      begin : memory
        forever begin
          @(negedge clk);
          MemValid = 1'b0;
          if (rst) begin
            mem_pend = 1'b0;
          end else begin
            if (mem_pend) begin
              mem_cnt--;
              if (mem_cnt == 0) begin
                MemValid = 1'b1;
                MemData  = 32'(mem_a) + 32'h100;
                mem_pend = 1'b0;
              end
            end
            if (MemRd) begin
              mem_pend = 1'b1;
              mem_cnt  = lat;
              mem_a    = MemAddr;
            end
          end
        end
      end
    join_none

    // Reset values
    apply_reset(1);
    chk("rst_memrd", 32'(MemRd), 32'd0);
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_ibus", InstructionBus, 32'h0000_00FF);
    chk("rst_ack", 32'(DataACKOut), 32'd0);
    chk("rst_pc", 32'(Pc), 32'd0);

    // Streaming fetch, latency, Enable dropped while a read is in flight
    expect_addrs(16'h0000, 3);
    expect_words(32'h100, 3);
    base = mrd_count;
    Enable = 1'b1;
    k = 0;
    while (!MemValid && k < 50) begin
      tick();
      k++;
    end
    tick();
    chk("lat_n1_ack", 32'(DataACKOut), 32'd0);
    tick();
    chk("lat_n2_ack", 32'(DataACKOut), 32'd1);
    wait_mrd(base + 3);
    Enable = 1'b0;
    drain();
    repeat (10) tick();
    chk("t1_no_more_rd", 32'(mrd_count), 32'(base + 3));

    // Stall fills the FIFO, then a back-to-back drain
    apply_reset(1);
    base = mrd_count;
    base_a = ack_count;
    Enable = 1'b1;
    Stall = 1'b1;
    repeat (20) tick();
    chk("t2_rd_pulses", 32'(mrd_count - base), 32'(DEPTH));
    chk("t2_ack_stalled", 32'(ack_count - base_a), 32'd0);
    chk("t2_pc", 32'(Pc), 32'(DEPTH));
    Enable = 1'b0;
    Stall = 1'b0;
    expect_words(32'h100, DEPTH);
    k = 0;
    while (!DataACKOut && k < 20) begin
      tick();
      k++;
    end
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk("t2_b2b_ack", 32'(DataACKOut), 32'd1);
    end
    drain();

    // Redirect in WAIT without MemValid: FLUSH, stale word and FIFO contents discarded
    apply_reset(4);
    Enable = 1'b1;
    Stall = 1'b1;
    base_a = ack_count;
    wait_mrd(mrd_count + 3);
    BranchEn = 1'b1;
    BranchAddr = 16'h0040;
    expect_addrs(16'h0040, DEPTH);
    base = mrd_count;
    tick();
    BranchEn = 1'b0;
    chk("t3_pc", 32'(Pc), 32'h40);
    chk("t3_ack", 32'(DataACKOut), 32'd0);
    repeat (60) tick();
    chk("t3_rd_after", 32'(mrd_count - base), 32'(DEPTH));
    chk("t3_no_ack", 32'(ack_count - base_a), 32'd0);
    Enable = 1'b0;
    Stall = 1'b0;
    expect_words(32'h140, DEPTH);
    drain();

    // Redirect coincident with MemValid and a pop that would otherwise happen
    apply_reset(1);
    Enable = 1'b1;
    Stall = 1'b1;
    wait_mrd(mrd_count + 3);
    tick();
    BranchEn = 1'b1;
    BranchAddr = 16'h0080;
    Stall = 1'b0;
    expect_addrs(16'h0080, DEPTH);
    base = mrd_count;
    tick();
    BranchEn = 1'b0;
    Stall = 1'b1;
    chk("t4_no_ack", 32'(DataACKOut), 32'd0);
    repeat (30) tick();
    chk("t4_rd_after", 32'(mrd_count - base), 32'(DEPTH));
    Enable = 1'b0;
    Stall = 1'b0;
    expect_words(32'h180, DEPTH);
    drain();

    // PC wrap from the top of the address space
    apply_reset(1);
    BranchEn = 1'b1;
    BranchAddr = 16'hFFFF;
    tick();
    BranchEn = 1'b0;
    chk("t5_idle_pc", 32'(Pc), 32'h0000_FFFF);
    chk("t5_idle_memaddr", 32'(MemAddr), 32'd0);
    expect_addrs(16'hFFFF, 3);
    exp_q.push_back(32'h0001_00FF);
    expect_words(32'h100, 2);
    base = mrd_count;
    Enable = 1'b1;
    wait_mrd(base + 3);
    Enable = 1'b0;
    drain();
    chk("t5_pc_wrapped", 32'(Pc), 32'd2);

    // Reset while a read is outstanding
    lat = 4;
    expect_addrs(16'h0002, 1);
    Enable = 1'b1;
    wait_mrd(mrd_count + 1);
    rst = 1'b1;
    Enable = 1'b0;
    tick();
    chk("t5_rst_memrd", 32'(MemRd), 32'd0);
    chk("t5_rst_memaddr", 32'(MemAddr), 32'd0);
    chk("t5_rst_ibus", InstructionBus, 32'h0000_00FF);
    chk("t5_rst_ack", 32'(DataACKOut), 32'd0);
    chk("t5_rst_pc", 32'(Pc), 32'd0);
    tick();
    rst = 1'b0;
    base = mrd_count;
    base_a = ack_count;
    repeat (10) tick();
    chk("t5_post_rst_rd", 32'(mrd_count - base), 32'd0);
    chk("t5_post_rst_ack", 32'(ack_count - base_a), 32'd0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
